// File: rtl/shift_sequencer_pkg.sv
// Shared types for the shift sequencer: op encoding, FSM states, datapath width.
package shift_sequencer_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ROR = 2'b00,
        ROL = 2'b01,
        SHR = 2'b10,
        SHL = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/shifter_rotator.sv
// One-step 8-bit combinational shifter/rotator; sel uses the op_t encoding.
module shifter_rotator
    import shift_sequencer_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    input  logic [1:0]        sel,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = x;
        case (op_t'(sel))
            ROR: y = {x[0], x[DATA_W-1:1]};
            ROL: y = {x[DATA_W-2:0], x[DATA_W-1]};
            SHR: y = {1'b0, x[DATA_W-1:1]};
            SHL: y = {x[DATA_W-2:0], 1'b0};
            default: y = x;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer: applies one single-bit step per RUN cycle.
// Optional early-abort input is enabled by defining SHIFT_SEQ_ABORT_EN.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        op,
    input  logic [CNT_W-1:0]  count,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] data_out
);

    state_t             state, state_n;
    op_t                op_q;
    logic [CNT_W-1:0]   rem;
    logic [DATA_W-1:0]  work, step;
    logic               abort_hit;

`ifdef SHIFT_SEQ_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    shifter_rotator u_step (
        .x   (work),
        .sel (op_q),
        .y   (step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start) state_n = (count == '0) ? DONE : RUN;
            RUN:  if (abort_hit || rem == CNT_W'(1)) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Working register holds its value outside RUN so the last result stays visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work <= '0;
            op_q <= ROR;
            rem  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    work <= data_in;
                    op_q <= op_t'(op);
                    rem  <= count;
                end
                RUN: begin
                    if (abort_hit) begin
                        rem <= '0;
                    end else begin
                        work <= step;
                        rem  <= rem - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign data_out = work;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus random jobs vs. an arithmetic model.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data_in = '0;
    logic [1:0] op = '0;
    logic [2:0] count = '0;
    logic       busy, done;
    logic [7:0] data_out;
`ifdef SHIFT_SEQ_ABORT_EN
    logic       abort = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    shift_sequencer #(.CNT_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .op       (op),
        .count    (count),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort    (abort),
`endif
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Whole-job result from the operation's definition, not from stepping.
    function automatic logic [7:0] model(input logic [7:0] d, input logic [1:0] o, input int n);
        int v, k;
        v = d;
        k = n % 8;
        case (o)
            2'b00: v = ((v >> k) | (v << (8 - k))) & 255;
            2'b01: v = ((v << k) | (v >> (8 - k))) & 255;
            2'b10: v = (n >= 8) ? 0 : (v >> n);
            default: v = (n >= 8) ? 0 : ((v << n) & 255);
        endcase
        return v[7:0];
    endfunction

    // Called at a negedge while IDLE; returns at the negedge of the following IDLE cycle.
    task automatic do_job(input string tag, input logic [7:0] d, input logic [1:0] o,
                          input logic [2:0] n, input logic [7:0] exp, input bit noise);
        start = 1'b1; data_in = d; op = o; count = n;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < int'(n); k++) begin
            chk({tag, "_run_busy"}, {7'b0, busy}, 8'd1);
            chk({tag, "_run_done"}, {7'b0, done}, 8'd0);
            if (noise) begin
                start = 1'b1; data_in = 8'($urandom); op = 2'($urandom); count = 3'($urandom);
            end
            @(negedge clk);
        end
        chk({tag, "_done"}, {7'b0, done}, 8'd1);
        chk({tag, "_done_busy"}, {7'b0, busy}, 8'd1);
        chk({tag, "_result"}, data_out, exp);
        if (noise) begin
            start = 1'b1; data_in = 8'($urandom); op = 2'($urandom); count = 3'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_idle_done"}, {7'b0, done}, 8'd0);
        chk({tag, "_idle_busy"}, {7'b0, busy}, 8'd0);
        chk({tag, "_hold"}, data_out, exp);
    endtask

    initial begin
        logic [7:0] d;
        logic [1:0] o;
        logic [2:0] n;

        #1;
        chk("rst_busy", {7'b0, busy}, 8'd0);
        chk("rst_done", {7'b0, done}, 8'd0);
        chk("rst_data", data_out, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_job("ror1", 8'h81, 2'b00, 3'd1, 8'hC0, 1'b0);
        do_job("rol3", 8'h81, 2'b01, 3'd3, 8'h0C, 1'b1);
        do_job("shr7", 8'hFF, 2'b10, 3'd7, 8'h01, 1'b1);
        do_job("shl7", 8'h01, 2'b11, 3'd7, 8'h80, 1'b0);
        do_job("cnt0", 8'h5A, 2'b01, 3'd0, 8'h5A, 1'b1);

        // Reset in the middle of a 5-step job.
        start = 1'b1; data_in = 8'hA5; op = 2'b01; count = 3'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mrst_data", data_out, 8'h00);
        chk("mrst_busy", {7'b0, busy}, 8'd0);
        chk("mrst_done", {7'b0, done}, 8'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mrst_nodone", {7'b0, done}, 8'd0);
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_nodone", {7'b0, done}, 8'd0);
        end
        do_job("post_rst", 8'h3C, 2'b00, 3'd5, model(8'h3C, 2'b00, 5), 1'b1);

`ifdef SHIFT_SEQ_ABORT_EN
        // Abort while the register holds 0x04 (after two steps) freezes it there.
        start = 1'b1; data_in = 8'h01; op = 2'b11; count = 3'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abt_partial", data_out, 8'h04);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abt_done", {7'b0, done}, 8'd1);
        chk("abt_data", data_out, 8'h04);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abt_single", {7'b0, done}, 8'd0);
            chk("abt_hold", data_out, 8'h04);
        end
`endif

        for (int j = 0; j < 40; j++) begin
            d = 8'($urandom);
            o = 2'($urandom);
            n = 3'($urandom);
            do_job("rand", d, o, n, model(d, o, int'(n)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
